// File: rtl/bus_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single fixed-latency SRAM port.
// Define ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module bus_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        sram_ce,
   output logic [3:0]  sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   output logic        stallreq_bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        cmd_data_q, cmd_data_d;
   logic        sram_ce_q, sram_ce_d;
   logic [3:0]  sram_we_q, sram_we_d;
   logic [31:0] sram_addr_q, sram_addr_d;
   logic [31:0] sram_wdata_q, sram_wdata_d;
   logic        i_ack_q, i_ack_d;
   logic        d_ack_q, d_ack_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        grant_data;

`ifdef ARB_RR_EN
   // last_data_q: 1 when the most recent grant went to the data port
   logic        last_data_q, last_data_d;
   assign grant_data = d_req & (~i_req | ~last_data_q);
`else
   assign grant_data = d_req;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cmd_data_d   = cmd_data_q;
      sram_ce_d    = sram_ce_q;
      sram_we_d    = sram_we_q;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      i_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
`ifdef ARB_RR_EN
      last_data_d  = last_data_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_req | d_req) begin
               state_d      = ACCESS;
               cnt_d        = WAIT_INIT;
               cmd_data_d   = grant_data;
               sram_ce_d    = 1'b1;
               sram_addr_d  = grant_data ? d_addr  : i_addr;
               sram_we_d    = grant_data ? d_we    : 4'b0000;
               sram_wdata_d = grant_data ? d_wdata : 32'h0;
`ifdef ARB_RR_EN
               last_data_d  = grant_data;
`endif
            end
         end
         ACCESS: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d   = RESP;
               sram_ce_d = 1'b0;
               sram_we_d = 4'b0000;
               // Data is captured on the final access edge; writes leave d_rdata alone
               if (cmd_data_q) begin
                  d_ack_d = 1'b1;
                  if (sram_we_q == 4'b0000)
                     d_rdata_d = sram_rdata;
               end else begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = sram_rdata;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         cmd_data_q   <= 1'b0;
         sram_ce_q    <= 1'b0;
         sram_we_q    <= 4'b0000;
         sram_addr_q  <= 32'h0;
         sram_wdata_q <= 32'h0;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         i_rdata_q    <= 32'h0;
         d_rdata_q    <= 32'h0;
`ifdef ARB_RR_EN
         last_data_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cmd_data_q   <= cmd_data_d;
         sram_ce_q    <= sram_ce_d;
         sram_we_q    <= sram_we_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
`ifdef ARB_RR_EN
         last_data_q  <= last_data_d;
`endif
      end
   end

   assign i_ack        = i_ack_q;
   assign d_ack        = d_ack_q;
   assign i_rdata      = i_rdata_q;
   assign d_rdata      = d_rdata_q;
   assign sram_ce      = sram_ce_q;
   assign sram_we      = sram_we_q;
   assign sram_addr    = sram_addr_q;
   assign sram_wdata   = sram_wdata_q;
   assign stallreq_bus = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (WAIT_CYCLES 1 and 3) share stimulus and are
// checked every cycle against a transaction-level model that counts cycles since grant.
module tb_bus_arbiter;
   localparam int W0 = 1;
   localparam int W1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        d_req;
   logic [3:0]  d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] sram_rdata;

   logic        o_iack [2];
   logic        o_dack [2];
   logic        o_ce [2];
   logic        o_stall [2];
   logic [3:0]  o_we [2];
   logic [31:0] o_irdata [2];
   logic [31:0] o_drdata [2];
   logic [31:0] o_addr [2];
   logic [31:0] o_wdata [2];

   bus_arbiter #(.WAIT_CYCLES(W0)) u_dut0 (
      .cpu_clk_50M(clk), .cpu_rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(o_iack[0]), .i_rdata(o_irdata[0]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(o_dack[0]), .d_rdata(o_drdata[0]),
      .sram_ce(o_ce[0]), .sram_we(o_we[0]), .sram_addr(o_addr[0]),
      .sram_wdata(o_wdata[0]), .sram_rdata(sram_rdata), .stallreq_bus(o_stall[0])
   );

   bus_arbiter #(.WAIT_CYCLES(W1)) u_dut1 (
      .cpu_clk_50M(clk), .cpu_rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(o_iack[1]), .i_rdata(o_irdata[1]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(o_dack[1]), .d_rdata(o_drdata[1]),
      .sram_ce(o_ce[1]), .sram_we(o_we[1]), .sram_addr(o_addr[1]),
      .sram_wdata(o_wdata[1]), .sram_rdata(sram_rdata), .stallreq_bus(o_stall[1])
   );

   int errors = 0;
   int checks = 0;
   int iack_cnt = 0;

   // Reference model: t = cycles since grant (0 = no transaction in flight)
   int          t [2];
   bit          cur_d [2];
   bit          last_d [2];
   logic [31:0] c_addr [2];
   logic [31:0] c_wdata [2];
   logic [3:0]  c_we [2];
   logic [31:0] e_irdata [2];
   logic [31:0] e_drdata [2];

   always @(negedge clk) if (o_iack[1] === 1'b1) iack_cnt++;

   function automatic int wv(input int k);
      return (k == 0) ? W0 : W1;
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         t[k] = 0; cur_d[k] = 1'b0; last_d[k] = 1'b0;
         c_addr[k] = 32'h0; c_wdata[k] = 32'h0; c_we[k] = 4'h0;
         e_irdata[k] = 32'h0; e_drdata[k] = 32'h0;
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         bit acc, ia, da;
         acc = (t[k] >= 1) && (t[k] <= wv(k));
         ia  = (t[k] == wv(k) + 1) && !cur_d[k];
         da  = (t[k] == wv(k) + 1) && cur_d[k];
         chk("sram_ce", k, {31'b0, o_ce[k]}, {31'b0, acc});
         chk("sram_we", k, {28'b0, o_we[k]}, acc ? {28'b0, c_we[k]} : 32'h0);
         chk("sram_addr", k, o_addr[k], c_addr[k]);
         chk("sram_wdata", k, o_wdata[k], c_wdata[k]);
         chk("i_ack", k, {31'b0, o_iack[k]}, {31'b0, ia});
         chk("d_ack", k, {31'b0, o_dack[k]}, {31'b0, da});
         chk("i_rdata", k, o_irdata[k], e_irdata[k]);
         chk("d_rdata", k, o_drdata[k], e_drdata[k]);
         chk("stallreq", k, {31'b0, o_stall[k]},
             {31'b0, (i_req & ~ia) | (d_req & ~da)});
      end
   endtask

   task automatic model_adv();
      for (int k = 0; k < 2; k++) begin
         if (t[k] == 0) begin
            if (i_req || d_req) begin
               bit pref, dsel;
`ifdef ARB_RR_EN
               pref = !last_d[k];
`else
               pref = 1'b1;
`endif
               dsel = d_req && (!i_req || pref);
               cur_d[k]   = dsel;
               last_d[k]  = dsel;
               c_addr[k]  = dsel ? d_addr : i_addr;
               c_we[k]    = dsel ? d_we : 4'h0;
               c_wdata[k] = dsel ? d_wdata : 32'h0;
               t[k] = 1;
            end
         end else if (t[k] == wv(k) + 1) begin
            t[k] = 0;
         end else begin
            if (t[k] == wv(k)) begin
               if (!cur_d[k]) e_irdata[k] = sram_rdata;
               else if (c_we[k] == 4'h0) e_drdata[k] = sram_rdata;
            end
            t[k] = t[k] + 1;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      model_adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 4'h0;
      d_addr = 32'h0; d_wdata = 32'h0; sram_rdata = 32'h0;
      model_reset();
      #3;
      check_all();
      @(posedge clk); #1;
      rst = 1'b0;

      // Single fetch, request dropped after the grant edge
      i_req = 1'b1; i_addr = 32'hBFC00000; sram_rdata = 32'h24080001;
      step();
      i_req = 1'b0;
      repeat (6) step();
      chk("fetch_data", 0, o_irdata[0], 32'h24080001);
      chk("fetch_data", 1, o_irdata[1], 32'h24080001);

      // Partial byte write
      d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h80000010; d_wdata = 32'h0000BEEF;
      sram_rdata = 32'hDEADBEEF;
      repeat (5) step();
      d_req = 1'b0; d_we = 4'h0;
      repeat (6) step();
      chk("write_keeps_rdata", 1, o_drdata[1], 32'h0);

      // Both requesters held high
      base = iack_cnt;
      i_req = 1'b1; d_req = 1'b1; i_addr = 32'h00001000; d_addr = 32'h00002000;
      for (int n = 0; n < 20; n++) begin
         sram_rdata = $urandom;
         step();
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (6) step();
`ifdef ARB_RR_EN
      chk("contention_iacks", 1, 32'(iack_cnt - base), 32'd2);
`else
      chk("contention_iacks", 1, 32'(iack_cnt - base), 32'd0);
`endif

      // Reset during cycle 2 of a read
      d_req = 1'b1; d_we = 4'h0; d_addr = 32'h80001234; sram_rdata = 32'hCAFEF00D;
      step();
      d_req = 1'b0;
      step();
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #1;
      rst = 1'b0;
      repeat (6) step();
      i_req = 1'b1; i_addr = 32'h80000040; sram_rdata = 32'h13572468;
      step();
      i_req = 1'b0;
      repeat (6) step();
      chk("after_reset_fetch", 1, o_irdata[1], 32'h13572468);

      // Data request arriving while a fetch is in flight
      i_req = 1'b1; i_addr = 32'h80000100;
      step();
      i_req = 1'b0; d_req = 1'b1; d_we = 4'h0; d_addr = 32'h80000200;
      for (int n = 0; n < 10; n++) begin
         sram_rdata = $urandom;
         step();
      end
      d_req = 1'b0;
      repeat (6) step();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         i_req      = ($urandom_range(2, 0) != 0);
         d_req      = ($urandom_range(2, 0) != 0);
         i_addr     = $urandom;
         d_addr     = $urandom;
         d_wdata    = $urandom;
         d_we       = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 0));
         sram_rdata = $urandom;
         step();
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (6) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
